// File: rtl/risc16_mem_pkg.sv
// Shared definitions for the RISC16 memory system: MMIO map, LED placement
// and byte-lane naming.
package risc16_mem_pkg;

    localparam int MMIO_WIN_W = 5;

    localparam logic [4:0] OFF_CNT_LO = 5'h10;
    localparam logic [4:0] OFF_CNT_HI = 5'h12;
    localparam logic [4:0] OFF_HALT   = 5'h1E;

    typedef enum logic {
        LANE_EVEN = 1'b0,
        LANE_ODD  = 1'b1
    } lane_e;

    // LED pairs share a word: even k sits in the odd (low) byte, odd k in the even byte.
    function automatic logic [4:0] led_off(input int k);
        return 5'(2 * (k / 2) + (((k % 2) == 0) ? 1 : 0));
    endfunction

endpackage

// File: rtl/risc16_bytebank.sv
// One byte lane of the memory: a single write port plus independent data and
// instruction read ports, either combinational or one-cycle registered.
module risc16_bytebank
    import risc16_mem_pkg::*;
#(
    parameter int    DEPTH     = 32768,
    parameter int    AW        = 15,
    parameter int    READ_REG  = 1,
    parameter        INIT_FILE = "",
    parameter lane_e LANE      = LANE_EVEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);

    logic [7:0] mem [DEPTH];

    // Not reset: contents survive rst, and a write in the reset cycle lands.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_a <= '0;
                    rdata_b <= '0;
                end else begin
                    if (re_a) rdata_a <= mem[raddr_a];
                    if (re_b) rdata_b <= mem[raddr_b];
                end
            end
        end else begin : g_rd_comb
            logic unused_rst;
            assign unused_rst = rst;
            assign rdata_a = re_a ? mem[raddr_a] : '0;
            assign rdata_b = re_b ? mem[raddr_b] : '0;
        end
    endgenerate

endmodule

// File: rtl/risc16_mem_sys.sv
// Big-endian RISC16 memory with instruction and data ports, LED bytes, a
// free-running cycle counter with coherent high-word shadow, and a halt flag.
module risc16_mem_sys
    import risc16_mem_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          MEM_BYTES = 65536,
    parameter int unsigned MMIO_BASE = 32'h0000_0200,
    parameter int          N_LED     = 3,
    parameter int          READ_REG  = 1,
    parameter              INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  iaddr,
    input  logic               ioe,
    output logic [15:0]        idin,
    output logic               ivalid,
    input  logic [ADDR_W-1:0]  daddr,
    input  logic [15:0]        ddout,
    input  logic               doe,
    input  logic               dwe0,
    input  logic               dwe1,
    output logic [15:0]        ddin,
    output logic               dvalid,
    output logic [8*N_LED-1:0] led,
    output logic               halted
);

    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int IDX_W  = MEM_AW - 1;
    localparam logic [ADDR_W-1:0] BASE = MMIO_BASE[ADDR_W-1:0];

    logic [IDX_W-1:0] i_idx, d_idx;
    logic [3:0]       d_woff;
    logic             d_mmio;
    logic [7:0]       d_even, d_odd, i_even, i_odd;

    assign i_idx  = iaddr[MEM_AW-1:1];
    assign d_idx  = daddr[MEM_AW-1:1];
    assign d_woff = daddr[4:1];
    assign d_mmio = (daddr[ADDR_W-1:MMIO_WIN_W] == BASE[ADDR_W-1:MMIO_WIN_W]);

    logic unused_bits;
    assign unused_bits = ^{iaddr, daddr};

    risc16_bytebank #(
        .DEPTH(MEM_BYTES / 2), .AW(IDX_W), .READ_REG(READ_REG),
        .INIT_FILE(INIT_FILE), .LANE(LANE_EVEN)
    ) u_even (
        .clk, .rst,
        .we(dwe0 & ~d_mmio), .waddr(d_idx), .wdata(ddout[15:8]),
        .re_a(doe & ~d_mmio), .raddr_a(d_idx), .rdata_a(d_even),
        .re_b(ioe), .raddr_b(i_idx), .rdata_b(i_even)
    );

    risc16_bytebank #(
        .DEPTH(MEM_BYTES / 2), .AW(IDX_W), .READ_REG(READ_REG),
        .INIT_FILE(INIT_FILE), .LANE(LANE_ODD)
    ) u_odd (
        .clk, .rst,
        .we(dwe1 & ~d_mmio), .waddr(d_idx), .wdata(ddout[7:0]),
        .re_a(doe & ~d_mmio), .raddr_a(d_idx), .rdata_a(d_odd),
        .re_b(ioe), .raddr_b(i_idx), .rdata_b(i_odd)
    );

    logic [N_LED-1:0][7:0]  led_q;
    logic [N_LED-1:0][15:0] led_rd;

    generate
        for (genvar k = 0; k < N_LED; k++) begin : g_led
            localparam logic [4:0] LO = led_off(k);
            localparam lane_e      LN = LO[0] ? LANE_ODD : LANE_EVEN;
            logic hit, lwe;
            assign hit = d_mmio && (d_woff == LO[4:1]);
            assign lwe = hit && ((LN == LANE_ODD) ? dwe1 : dwe0);

            always_ff @(posedge clk) begin
                if (rst)      led_q[k] <= '0;
                else if (lwe) led_q[k] <= (LN == LANE_ODD) ? ddout[7:0] : ddout[15:8];
            end

            assign led_rd[k] = !hit ? 16'h0000 :
                               (LN == LANE_ODD) ? {8'h00, led_q[k]} : {led_q[k], 8'h00};
        end
    endgenerate

    assign led = led_q;

    logic [31:0] cnt;
    logic [15:0] shadow;
    logic        halt_we, lo_rd;

    assign halt_we = d_mmio && (d_woff == OFF_HALT[4:1]) && (dwe0 || dwe1);
    assign lo_rd   = d_mmio && doe && (d_woff == OFF_CNT_LO[4:1]);

    // The HALT-write edge still increments; the counter freezes from then on.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            shadow <= '0;
            halted <= 1'b0;
        end else begin
            if (!halted) cnt    <= cnt + 32'd1;
            if (halt_we) halted <= 1'b1;
            if (lo_rd)   shadow <= cnt[31:16];
        end
    end

    logic [15:0] mmio_rd;

    always_comb begin
        mmio_rd = '0;
        for (int k = 0; k < N_LED; k++) mmio_rd = mmio_rd | led_rd[k];
        if (d_woff == OFF_CNT_LO[4:1])      mmio_rd = cnt[15:0];
        else if (d_woff == OFF_CNT_HI[4:1]) mmio_rd = shadow;
    end

    logic        iv_q, dv_q, dsel_q;
    logic [15:0] dmm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q   <= 1'b0;
            dv_q   <= 1'b0;
            dsel_q <= 1'b0;
            dmm_q  <= '0;
        end else begin
            iv_q <= ioe;
            dv_q <= doe;
            if (doe) begin
                dsel_q <= d_mmio;
                dmm_q  <= mmio_rd;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_out_reg
            assign idin   = {i_even, i_odd};
            assign ivalid = iv_q;
            assign ddin   = dsel_q ? dmm_q : {d_even, d_odd};
            assign dvalid = dv_q;
        end else begin : g_out_comb
            assign idin   = {i_even, i_odd};
            assign ivalid = ioe;
            assign ddin   = !doe ? 16'h0000 : d_mmio ? mmio_rd : {d_even, d_odd};
            assign dvalid = doe;
        end
    endgenerate

endmodule

// File: tb/tb_risc16_mem_sys.sv
// Directed bench for risc16_mem_sys (registered reads, 17-bit addresses to
// exercise aliasing onto a 64 KiB memory).
module tb_risc16_mem_sys;

    localparam int AW = 17;
    localparam int NL = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   iaddr = '0, daddr = '0;
    logic            ioe = 1'b0, doe = 1'b0, dwe0 = 1'b0, dwe1 = 1'b0;
    logic [15:0]     ddout = '0;
    logic [15:0]     idin, ddin;
    logic            ivalid, dvalid, halted;
    logic [8*NL-1:0] led;

    risc16_mem_sys #(
        .ADDR_W(AW), .MEM_BYTES(65536), .MMIO_BASE(32'h200),
        .N_LED(NL), .READ_REG(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst),
        .iaddr(iaddr), .ioe(ioe), .idin(idin), .ivalid(ivalid),
        .daddr(daddr), .ddout(ddout), .doe(doe), .dwe0(dwe0), .dwe1(dwe1),
        .ddin(ddin), .dvalid(dvalid), .led(led), .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference count of non-reset edges: the counter value an edge will sample.
    logic [31:0] ecount;
    always @(posedge clk) begin
        if (rst) ecount <= '0;
        else     ecount <= ecount + 32'd1;
    end

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        string         nm;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic          oe, w0, w1;
        logic [15:0]   exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic oe, input logic w0, input logic w1, input logic [15:0] exp);
        vec_t v;
        v.nm = nm; v.a = a; v.d = d; v.oe = oe; v.w0 = w0; v.w1 = w1; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drv(input logic [AW-1:0] ia, input logic io, input logic [AW-1:0] da,
                       input logic [15:0] dd, input logic oe, input logic w0, input logic w1);
        iaddr = ia; ioe = io; daddr = da; ddout = dd; doe = oe; dwe0 = w0; dwe1 = w1;
    endtask

    task automatic idle();
        drv('0, 1'b0, '0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dread(input logic [AW-1:0] a);
        drv('0, 1'b0, a, 16'h0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic dwrite(input logic [AW-1:0] a, input logic [15:0] d, input logic w0, input logic w1);
        drv('0, 1'b0, a, d, 1'b0, w0, w1);
        tick();
    endtask

    logic [31:0] e, hv;
    int          g;

    initial begin
        //          name            addr        data     oe w0 w1 expected
        add("wr beef",      17'h0C000, 16'hBEEF, 0, 1, 1, 16'h0000);
        add("rd c000",      17'h0C000, 16'h0000, 1, 0, 0, 16'hBEEF);
        add("rd c001",      17'h0C001, 16'h0000, 1, 0, 0, 16'hBEEF);
        add("wr aaaa",      17'h0C002, 16'hAAAA, 0, 1, 1, 16'h0000);
        add("wr odd 34",    17'h0C002, 16'h1234, 0, 0, 1, 16'h0000);
        add("rd aa34",      17'h0C002, 16'h0000, 1, 0, 0, 16'hAA34);
        add("wr even 56",   17'h0C002, 16'h5600, 0, 1, 0, 16'h0000);
        add("rd 5634",      17'h0C003, 16'h0000, 1, 0, 0, 16'h5634);
        add("wr mem 200",   17'h10200, 16'h5A5A, 0, 1, 1, 16'h0000);
        add("wr mem 202",   17'h10202, 16'h6B6B, 0, 1, 1, 16'h0000);
        add("wr led01",     17'h00200, 16'h0201, 0, 1, 1, 16'h0000);
        add("wr led2",      17'h00202, 16'h0003, 0, 0, 1, 16'h0000);
        add("rd led2",      17'h00202, 16'h0000, 1, 0, 0, 16'h0003);
        add("rd led01",     17'h00201, 16'h0000, 1, 0, 0, 16'h0201);
        add("rd unused",    17'h00204, 16'h0000, 1, 0, 0, 16'h0000);
        add("wr unused",    17'h00204, 16'hFFFF, 0, 1, 1, 16'h0000);
        add("rd unused2",   17'h00204, 16'h0000, 1, 0, 0, 16'h0000);
        add("rd alias 200", 17'h10200, 16'h0000, 1, 0, 0, 16'h5A5A);
        add("rd alias c000",17'h1C000, 16'h0000, 1, 0, 0, 16'hBEEF);

        idle();
        repeat (2) @(negedge clk);
        chk("reset idin",   idin,   32'h0);
        chk("reset ddin",   ddin,   32'h0);
        chk("reset ivalid", ivalid, 32'h0);
        chk("reset dvalid", dvalid, 32'h0);
        chk("reset led",    led,    32'h0);
        chk("reset halted", halted, 32'h0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drv('0, 1'b0, vq[i].a, vq[i].d, vq[i].oe, vq[i].w0, vq[i].w1);
            tick();
            chk({vq[i].nm, " dvalid"}, dvalid, {31'h0, vq[i].oe});
            if (vq[i].oe) chk({vq[i].nm, " ddin"}, ddin, {16'h0, vq[i].exp});
        end
        idle();
        tick();
        chk("dvalid one cycle", dvalid, 32'h0);
        chk("ddin holds",       ddin,   32'hBEEF);
        chk("led value",        led,    32'h030201);

        drv(17'h00200, 1'b1, '0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("imem 200 untouched", idin,   32'h5A5A);
        chk("ivalid",             ivalid, 32'h1);
        drv(17'h00202, 1'b1, '0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("imem 202 untouched", idin, 32'h6B6B);

        // Read-during-write on both ports returns old data.
        dwrite(17'h0C010, 16'h2222, 1'b1, 1'b1);
        drv(17'h0C010, 1'b1, 17'h0C010, 16'h1111, 1'b0, 1'b1, 1'b1);
        tick();
        chk("i raw old", idin, 32'h2222);
        drv(17'h1C010, 1'b1, '0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("i raw new alias", idin, 32'h1111);
        drv('0, 1'b0, 17'h0C010, 16'h3333, 1'b1, 1'b1, 1'b1);
        tick();
        chk("d raw old", ddin, 32'h1111);
        dread(17'h0C010);
        chk("d raw new", ddin, 32'h3333);
        idle();

        // Counter sampled at cycle 1000 after release.
        for (g = 0; g < 2000 && ecount != 32'd1000; g++) tick();
        e = ecount;
        dread(17'h00210);
        chk("cnt_lo @1000", ddin, {16'h0, e[15:0]});
        dread(17'h00212);
        chk("cnt_hi @1000", ddin, {16'h0, e[31:16]});
        idle();

        // Low word sampled at FFFF; the high word must come from the shadow.
        for (g = 0; g < 70000 && ecount != 32'h0000FFFF; g++) tick();
        if (ecount != 32'h0000FFFF) begin
            n_tot++;
            $display("FAIL wrap wait: reached %h expected 0000ffff", ecount);
        end
        dread(17'h00210);
        chk("cnt_lo ffff", ddin, 32'hFFFF);
        dread(17'h00212);
        chk("cnt_hi shadow 0", ddin, 32'h0000);
        dread(17'h00210);
        chk("cnt_lo after wrap", ddin, 32'h0001);
        dread(17'h00212);
        chk("cnt_hi after wrap", ddin, 32'h0001);
        idle();
        tick();

        e = ecount;
        dwrite(17'h0021E, 16'h0000, 1'b1, 1'b0);
        chk("halted set", halted, 32'h1);
        hv = e + 32'd1;
        dread(17'h00210);
        chk("cnt frozen", ddin, {16'h0, hv[15:0]});
        idle();
        repeat (50) tick();
        chk("halted sticky", halted, 32'h1);
        dread(17'h00210);
        chk("cnt frozen 50", ddin, {16'h0, hv[15:0]});
        dwrite(17'h0C020, 16'h7777, 1'b1, 1'b1);
        dread(17'h0C020);
        chk("mem after halt", ddin, 32'h7777);
        dwrite(17'h00200, 16'h0055, 1'b0, 1'b1);
        chk("led after halt", led, 32'h030255);

        // Reset cycle: memory write lands, MMIO write and reads are dropped.
        rst = 1'b1;
        drv('0, 1'b0, 17'h0C030, 16'h4242, 1'b1, 1'b1, 1'b1);
        tick();
        drv('0, 1'b0, 17'h00200, 16'h00FF, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        chk("rst halted", halted, 32'h0);
        chk("rst led",    led,    32'h0);
        chk("rst dvalid", dvalid, 32'h0);
        chk("rst ddin",   ddin,   32'h0);
        dread(17'h00210);
        chk("rst cnt", ddin, 32'h0000);
        dread(17'h0C030);
        chk("write in rst", ddin, 32'h4242);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
